// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART RX register-side logic.
//   rx_if_state_t    : RBR prefetch FSM states
//   LSR_*            : line-status register bit positions
//   RX_TIMEOUT_CHARS : default character-timeout threshold
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rx_if_state_t;

  localparam int unsigned LSR_DR = 0;
  localparam int unsigned LSR_OE = 1;
  localparam int unsigned LSR_FE = 3;

  localparam int unsigned RX_TIMEOUT_CHARS = 4;

endpackage : uart_pkg

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for a single level crossing into clk's domain.
//   clk  : destination clock
//   rst  : asynchronous active-high reset, clears all stages
//   d    : asynchronous level in
//   q    : synchronised level out (STAGES cycles of latency)
// ---------------------------------------------------------------------------
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; stage 0 is the metastability-catching flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule : bit_sync

// File: rtl/uart_rx_reg_if.sv
// ---------------------------------------------------------------------------
// uart_rx_reg_if
// Register-side consumer of the UART RX path (rd_clk domain). Prefetches
// bytes from the RX async FIFO into the receive holding register, keeps
// sticky frame/overrun status and raises the RX interrupt.
//   rd_clk, rd_rst          : clock, asynchronous active-high reset
//   fifo_rd_data/_empty/_en : RX FIFO read port (data valid cycle after _en)
//   clear                   : software RX flush pulse
//   rbr_rd, rbr_data        : host read strobe and holding register
//   data_ready              : RBR holds an unread byte
//   lsr_rd, lsr_fe, lsr_oe  : LSR read strobe and sticky error bits
//   frame/overrun_error_async : uart_clk-domain error levels
//   char_tick, timeout      : character-time pulse and timeout status
//   ier_rx/_to/_err, irq    : interrupt enables and registered interrupt
// ---------------------------------------------------------------------------
module uart_rx_reg_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TIMEOUT_CHARS = RX_TIMEOUT_CHARS,
  parameter int unsigned TO_CNT_W      = 3
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  fifo_rd_en,
  input  logic                  clear,
  input  logic                  rbr_rd,
  output logic [DATA_WIDTH-1:0] rbr_data,
  output logic                  data_ready,
  input  logic                  lsr_rd,
  input  logic                  frame_error_async,
  input  logic                  overrun_error_async,
  output logic                  lsr_fe,
  output logic                  lsr_oe,
  input  logic                  char_tick,
  input  logic                  ier_rx,
  input  logic                  ier_to,
  input  logic                  ier_err,
  output logic                  timeout,
  output logic                  irq
);

  localparam logic [TO_CNT_W-1:0] TO_MAX = TO_CNT_W'(TIMEOUT_CHARS);

  rx_if_state_t        state;
  rx_if_state_t        state_nxt;
  logic                load_rbr;
  logic [TO_CNT_W-1:0] to_cnt;
  logic [TO_CNT_W-1:0] to_cnt_nxt;
  logic                fe_sync;
  logic                oe_sync;
  logic                fe_sync_d;
  logic                oe_sync_d;
  logic                fe_rise;
  logic                oe_rise;

  // State register.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and pop strobe; fifo_rd_en must be a same-cycle strobe to the FIFO.
  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    load_rbr   = 1'b0;
    case (state)
      EMPTY: begin
        if (!fifo_rd_empty && !clear) begin
          fifo_rd_en = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        load_rbr  = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (rbr_rd) begin
          if (!fifo_rd_empty && !clear) begin
            fifo_rd_en = 1'b1;
            state_nxt  = FETCH;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A flush drops any in-flight byte; rbr_data keeps its last value.
    if (clear) begin
      state_nxt = EMPTY;
      load_rbr  = 1'b0;
    end
  end

  // Holding register and its valid flag.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rbr_data   <= '0;
      data_ready <= 1'b0;
    end else begin
      if (load_rbr) begin
        rbr_data <= fifo_rd_data;
      end
      if (clear) begin
        data_ready <= 1'b0;
      end else if (load_rbr) begin
        data_ready <= 1'b1;
      end else if (state == HOLD && rbr_rd) begin
        data_ready <= 1'b0;
      end
    end
  end

  // Inactivity counter: only runs while there is something unread.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (clear || rbr_rd || fifo_rd_en || (!data_ready && fifo_rd_empty)) begin
      to_cnt_nxt = '0;
    end else if (char_tick && to_cnt != TO_MAX) begin
      to_cnt_nxt = to_cnt + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      to_cnt  <= to_cnt_nxt;
      timeout <= (to_cnt_nxt == TO_MAX);
    end
  end

  // Error levels crossing from uart_clk.
  bit_sync #(.STAGES(2)) u_fe_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (frame_error_async),
    .q   (fe_sync)
  );

  bit_sync #(.STAGES(2)) u_oe_sync (
    .clk (rd_clk),
    .rst (rd_rst),
    .d   (overrun_error_async),
    .q   (oe_sync)
  );

  assign fe_rise = fe_sync & ~fe_sync_d;
  assign oe_rise = oe_sync & ~oe_sync_d;

  // Sticky status; a new rising edge beats a simultaneous LSR read.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      fe_sync_d <= 1'b0;
      oe_sync_d <= 1'b0;
      lsr_fe    <= 1'b0;
      lsr_oe    <= 1'b0;
    end else begin
      fe_sync_d <= fe_sync;
      oe_sync_d <= oe_sync;
      if (fe_rise) begin
        lsr_fe <= 1'b1;
      end else if (lsr_rd) begin
        lsr_fe <= 1'b0;
      end
      if (oe_rise) begin
        lsr_oe <= 1'b1;
      end else if (lsr_rd) begin
        lsr_oe <= 1'b0;
      end
    end
  end

  // Interrupt, one cycle behind its registered sources.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (ier_rx & data_ready) | (ier_to & timeout) | (ier_err & (lsr_fe | lsr_oe));
    end
  end

endmodule : uart_rx_reg_if

// File: tb/tb_uart_rx_reg_if.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_reg_if
// Directed bench for uart_rx_reg_if with a FIFO model, a behavioural
// reference model and literal checkpoints.
// ---------------------------------------------------------------------------
module tb_uart_rx_reg_if;

  localparam int TIMEOUT = 4;

  logic       rd_clk = 1'b0;
  logic       rd_rst;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_rd_empty;
  logic       fifo_rd_en;
  logic       clear;
  logic       rbr_rd;
  logic [7:0] rbr_data;
  logic       data_ready;
  logic       lsr_rd;
  logic       frame_error_async;
  logic       overrun_error_async;
  logic       lsr_fe;
  logic       lsr_oe;
  logic       char_tick;
  logic       ier_rx;
  logic       ier_to;
  logic       ier_err;
  logic       timeout;
  logic       irq;

  int tests = 0;
  int fails = 0;

  always #5 rd_clk = ~rd_clk;

  uart_rx_reg_if #(
    .DATA_WIDTH    (8),
    .TIMEOUT_CHARS (TIMEOUT),
    .TO_CNT_W      (3)
  ) dut (
    .rd_clk              (rd_clk),
    .rd_rst              (rd_rst),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_en          (fifo_rd_en),
    .clear               (clear),
    .rbr_rd              (rbr_rd),
    .rbr_data            (rbr_data),
    .data_ready          (data_ready),
    .lsr_rd              (lsr_rd),
    .frame_error_async   (frame_error_async),
    .overrun_error_async (overrun_error_async),
    .lsr_fe              (lsr_fe),
    .lsr_oe              (lsr_oe),
    .char_tick           (char_tick),
    .ier_rx              (ier_rx),
    .ier_to              (ier_to),
    .ier_err             (ier_err),
    .timeout             (timeout),
    .irq                 (irq)
  );

  // FIFO model: stimulus writes mem/wr_ptr, pops return data next cycle.
  logic [7:0] mem [0:31];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  assign fifo_rd_empty = (wr_ptr == rd_ptr);

  always @(posedge rd_clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_rd_data <= mem[rd_ptr[4:0]];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // Reference model: a byte is "in flight" for one cycle after a pop.
  logic [7:0] m_rbr, n_rbr;
  logic       m_dr, n_dr, m_infl, n_infl, m_to, n_to;
  logic       m_fe, n_fe, m_oe, n_oe, m_irq, n_irq, n_en;
  int         m_cnt, n_cnt;
  logic [2:0] fe_h, oe_h;   // [k] = async level sampled k+1 edges ago

  always_comb begin
    n_en   = (wr_ptr != rd_ptr) && !clear && !m_infl && (!m_dr || rbr_rd);
    n_rbr  = m_rbr;
    n_dr   = m_dr;
    n_infl = m_infl;
    if (clear) begin
      n_dr   = 1'b0;
      n_infl = 1'b0;
    end else begin
      if (m_infl) begin
        n_rbr  = fifo_rd_data;
        n_dr   = 1'b1;
        n_infl = 1'b0;
      end else if (rbr_rd) begin
        n_dr = 1'b0;
      end
      if (n_en) n_infl = 1'b1;
    end
    if (clear || rbr_rd || n_en || (!m_dr && wr_ptr == rd_ptr)) n_cnt = 0;
    else if (char_tick && m_cnt < TIMEOUT) n_cnt = m_cnt + 1;
    else n_cnt = m_cnt;
    n_to  = (n_cnt == TIMEOUT);
    // Sticky bit sets when the level seen 2 edges ago rose relative to 3 edges ago.
    n_fe  = (fe_h[1] && !fe_h[2]) ? 1'b1 : (lsr_rd ? 1'b0 : m_fe);
    n_oe  = (oe_h[1] && !oe_h[2]) ? 1'b1 : (lsr_rd ? 1'b0 : m_oe);
    n_irq = (ier_rx && m_dr) || (ier_to && m_to) || (ier_err && (m_fe || m_oe));
  end

  always @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      m_rbr <= 8'h00; m_dr <= 1'b0; m_infl <= 1'b0; m_to <= 1'b0;
      m_fe <= 1'b0; m_oe <= 1'b0; m_irq <= 1'b0; m_cnt <= 0;
      fe_h <= 3'b000; oe_h <= 3'b000;
    end else begin
      m_rbr <= n_rbr; m_dr <= n_dr; m_infl <= n_infl; m_to <= n_to;
      m_fe <= n_fe; m_oe <= n_oe; m_irq <= n_irq; m_cnt <= n_cnt;
      fe_h <= {fe_h[1:0], frame_error_async};
      oe_h <= {oe_h[1:0], overrun_error_async};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (!rd_rst) begin
      check("model_rbr_data",   32'(rbr_data),   32'(m_rbr));
      check("model_data_ready", 32'(data_ready), 32'(m_dr));
      check("model_fifo_rd_en", 32'(fifo_rd_en), 32'(n_en));
      check("model_lsr_fe",     32'(lsr_fe),     32'(m_fe));
      check("model_lsr_oe",     32'(lsr_oe),     32'(m_oe));
      check("model_timeout",    32'(timeout),    32'(m_to));
      check("model_irq",        32'(irq),        32'(m_irq));
      check("pop_while_empty",  32'(fifo_rd_en & fifo_rd_empty), 32'd0);
    end
  endtask

  // One cycle: compare on the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge rd_clk);
    compare_all();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[4:0]] = b;
    wr_ptr++;
  endtask

  task automatic wait_dr(input string name);
    int n;
    n = 0;
    while (!data_ready && n < 10) begin
      cyc();
      n++;
    end
    check(name, 32'(data_ready), 32'd1);
  endtask

  logic [7:0] got [0:2];
  int         ngot;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_rst = 1'b1; clear = 1'b0; rbr_rd = 1'b0; lsr_rd = 1'b0;
    frame_error_async = 1'b0; overrun_error_async = 1'b0; char_tick = 1'b0;
    ier_rx = 1'b0; ier_to = 1'b0; ier_err = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1;
    check("reset_rbr_data",   32'(rbr_data),   32'h0);
    check("reset_data_ready", 32'(data_ready), 32'h0);
    check("reset_fifo_rd_en", 32'(fifo_rd_en), 32'h0);
    check("reset_irq",        32'(irq),        32'h0);
    rd_rst = 1'b0;
    cyc();

    // Single byte: pop, then RBR valid two edges later, irq one after that.
    ier_rx = 1'b1;
    push(8'hA5);
    #1;
    check("a5_pop", 32'(fifo_rd_en), 32'd1);
    cyc();
    check("a5_pop_one_cycle", 32'(fifo_rd_en), 32'd0);
    check("a5_not_ready_yet", 32'(data_ready), 32'd0);
    cyc();
    check("a5_rbr_data",   32'(rbr_data),   32'hA5);
    check("a5_data_ready", 32'(data_ready), 32'd1);
    check("a5_irq_lag",    32'(irq),        32'd0);
    cyc();
    check("a5_irq", 32'(irq), 32'd1);
    rbr_rd = 1'b1; cyc(); rbr_rd = 1'b0;
    check("a5_read_clears_dr", 32'(data_ready), 32'd0);
    cyc(); cyc();

    // Three queued bytes read out as soon as each becomes ready.
    push(8'h11); push(8'h22); push(8'h33);
    ngot = 0;
    for (int i = 0; i < 20 && ngot < 3; i++) begin
      rbr_rd = data_ready;
      if (data_ready) begin
        got[ngot] = rbr_data;
        ngot++;
      end
      cyc();
    end
    rbr_rd = 1'b0;
    check("burst_count", 32'(ngot), 32'd3);
    check("burst_byte0", 32'(got[0]), 32'h11);
    check("burst_byte1", 32'(got[1]), 32'h22);
    check("burst_byte2", 32'(got[2]), 32'h33);
    check("burst_dr_after", 32'(data_ready), 32'd0);
    cyc();
    check("burst_no_pop_empty", 32'(fifo_rd_en), 32'd0);

    // Frame error: 3-cycle latency, set beats a simultaneous LSR read.
    ier_err = 1'b1;
    frame_error_async = 1'b1;
    cyc(); cyc();
    check("fe_latency_not_yet", 32'(lsr_fe), 32'd0);
    cyc();
    check("fe_set", 32'(lsr_fe), 32'd1);
    lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
    check("fe_lsr_rd_clears", 32'(lsr_fe), 32'd0);
    frame_error_async = 1'b0;
    repeat (4) cyc();
    frame_error_async = 1'b1;
    cyc(); cyc();
    lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
    check("fe_set_wins", 32'(lsr_fe), 32'd1);
    cyc();
    lsr_rd = 1'b1; cyc(); lsr_rd = 1'b0;
    check("fe_later_clear", 32'(lsr_fe), 32'd0);
    frame_error_async = 1'b0;
    repeat (3) cyc();

    // Character timeout with an unread byte.
    ier_to = 1'b1;
    push(8'h5C);
    wait_dr("to_byte_ready");
    for (int k = 1; k <= 5; k++) begin
      char_tick = 1'b1; cyc(); char_tick = 1'b0;
      if (k == 3) check("to_after_3", 32'(timeout), 32'd0);
      if (k == 4) check("to_after_4", 32'(timeout), 32'd1);
      if (k == 5) check("to_saturated", 32'(timeout), 32'd1);
      cyc();
    end
    rbr_rd = 1'b1; cyc(); rbr_rd = 1'b0;
    check("to_cleared_by_read", 32'(timeout), 32'd0);
    cyc(); cyc();

    // Flush during FETCH discards the in-flight byte, then refetch resumes.
    push(8'h66); push(8'h77);
    cyc();
    clear = 1'b1;
    #1;
    check("clr_no_pop", 32'(fifo_rd_en), 32'd0);
    cyc();
    clear = 1'b0;
    #1;
    check("clr_dr_low", 32'(data_ready), 32'd0);
    check("clr_rbr_stale", 32'(rbr_data), 32'h5C);
    check("clr_refetch", 32'(fifo_rd_en), 32'd1);
    cyc(); cyc();
    check("clr_next_byte", 32'(rbr_data), 32'h77);
    check("clr_next_dr", 32'(data_ready), 32'd1);

    // Asynchronous reset while holding data with an overrun flagged.
    overrun_error_async = 1'b1;
    repeat (3) cyc();
    check("rst_pre_oe", 32'(lsr_oe), 32'd1);
    check("rst_pre_dr", 32'(data_ready), 32'd1);
    #2;
    rd_rst = 1'b1;
    #1;
    check("arst_rbr_data",   32'(rbr_data),   32'h0);
    check("arst_data_ready", 32'(data_ready), 32'd0);
    check("arst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    check("arst_lsr_oe",     32'(lsr_oe),     32'd0);
    check("arst_lsr_fe",     32'(lsr_fe),     32'd0);
    check("arst_timeout",    32'(timeout),    32'd0);
    check("arst_irq",        32'(irq),        32'd0);
    repeat (2) @(posedge rd_clk);
    #1;
    rd_rst = 1'b0;
    repeat (6) cyc();
    check("post_rst_oe_resync", 32'(lsr_oe), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_rx_reg_if

// File: doc/uart_rx_reg_if.md
Name: uart_rx_reg_if

Overview:
- Read-side consumer of the RX path. Lives in the rd_clk (register/AXI) domain.
- Prefetches bytes from the RX async FIFO into a receive holding register (RBR), which the register file reads.
- Synchronises the uart_clk-domain frame/overrun flags into sticky line-status bits.
- Generates the RX interrupt from three sources: data-ready, character timeout and error.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and RBR.
- TIMEOUT_CHARS, 4, char_tick pulses of inactivity before timeout asserts.
- TO_CNT_W, 3, timeout counter width; must satisfy 2**TO_CNT_W > TIMEOUT_CHARS.

Ports:
- rd_clk  in  1  sole clock.
- rd_rst  in  1  asynchronous, active-high reset.
- fifo_rd_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_empty  in  1  FIFO empty (rd_clk domain).
- fifo_rd_en  out  1  FIFO pop strobe.
- clear  in  1  software RX flush pulse, same as the FIFO's rd_clear.
- rbr_rd  in  1  one-cycle pulse: host read of RBR.
- rbr_data  out  DATA_WIDTH  holding register.
- data_ready  out  1  RBR holds an unread byte.
- lsr_rd  in  1  one-cycle pulse: host read of line status; clears sticky errors.
- frame_error_async  in  1  uart_clk-domain frame error level.
- overrun_error_async  in  1  uart_clk-domain sticky overrun level.
- lsr_fe  out  1  sticky frame error.
- lsr_oe  out  1  sticky overrun error.
- char_tick  in  1  one-cycle pulse per character time, generated in rd_clk.
- ier_rx  in  1  data-ready interrupt enable.
- ier_to  in  1  timeout interrupt enable.
- ier_err  in  1  error interrupt enable.
- timeout  out  1  character-timeout status.
- irq  out  1  registered RX interrupt.

Behaviour:
- Reset: state=EMPTY, rbr_data=0, data_ready=0, fifo_rd_en=0, lsr_fe=0, lsr_oe=0, timeout=0, timeout counter=0, irq=0, sync flops=0.
- FSM states:
  - EMPTY: if !fifo_rd_empty && !clear, assert fifo_rd_en (combinational, one cycle) and go to FETCH.
  - FETCH: load rbr_data<=fifo_rd_data, set data_ready=1, go to HOLD. rbr_rd in this state is ignored.
  - HOLD: on rbr_rd, clear data_ready.
    - If !fifo_rd_empty at the same time, assert fifo_rd_en and go to FETCH; otherwise go to EMPTY.
    - Back-to-back throughput: one byte per 2 cycles.
- fifo_rd_en is never asserted when fifo_rd_empty=1, when clear=1, or in FETCH.
- clear:
  - Highest priority: next state EMPTY, data_ready<=0, timeout and counter <=0. rbr_data holds its value.
  - clear during FETCH discards the in-flight byte.
- rbr_rd while data_ready=0: no state change; rbr_data returns its stale value.
- Error sync:
  - frame_error_async and overrun_error_async each pass through bit_sync (STAGES=2).
  - A rising edge of a synchronised level sets the matching sticky bit.
  - lsr_rd clears both sticky bits; if a set and lsr_rd occur in the same cycle, set wins.
  - Latency from async rise to sticky bit: 3 rd_clk cycles.
- Timeout counter:
  - Counts char_tick only while data_ready=1 or !fifo_rd_empty.
  - Reset to 0 on rbr_rd, on fifo_rd_en, or when both empty conditions hold.
  - Saturates at TIMEOUT_CHARS; timeout=1 while at saturation.
  - timeout clears on rbr_rd or clear.
- irq is registered, 1 cycle after its sources: irq <= (ier_rx&data_ready) | (ier_to&timeout) | (ier_err&(lsr_fe|lsr_oe)).

Decomposition:
- uart_pkg holds:
  - rx_if_state_t enum {EMPTY, FETCH, HOLD};
  - LSR bit index constants (LSR_DR=0, LSR_OE=1, LSR_FE=3);
  - default TIMEOUT_CHARS constant.
- Reuse the existing bit_sync sub-module, two instances. No other sub-module.

Test Plan:
- Reset then push 0xA5 into the FIFO model → fifo_rd_en one pulse, data_ready=1 and rbr_data=0xA5 two cycles after empty deasserts. irq=1 one cycle later when ier_rx=1.
- Preload 3 bytes 0x11,0x22,0x33; rbr_rd on each cycle data_ready=1 → host sees 0x11,0x22,0x33 in order. No pop while empty; data_ready=0 after the third read.
- Pulse frame_error_async for 1 uart_clk (held ≥3 rd_clk) → lsr_fe=1 after 3 cycles. lsr_rd in the same cycle as a second rising edge → lsr_fe stays 1; a later lsr_rd → 0.
- With data_ready=1 and no reads, issue 4 char_tick pulses → timeout=1 after the 4th; a 5th pulse keeps it at 1. rbr_rd → timeout=0, counter=0.
- clear asserted during FETCH with 2 bytes queued → data_ready stays 0 and no fifo_rd_en that cycle; refetch resumes the cycle after clear drops if the FIFO is non-empty.
- Assert rd_rst in HOLD with data_ready=1 and lsr_oe=1 → all outputs 0 immediately (asynchronously), state EMPTY.
